load_power_scheduler: RTL and testbench

//  Arbitrates appliance load requests (light, fan, AC, heating, cooling) under a

---
 rtl/load_power_scheduler_pkg.sv | 28 ++
 rtl/load_power_scheduler_if.sv | 21 ++
 rtl/load_power_scheduler_load_hold_timer.sv | 30 +++
 rtl/load_power_scheduler.sv | 109 ++++++++++
 tb/tb_load_power_scheduler.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/load_power_scheduler_pkg.sv
// Shared types and constants for the appliance load scheduler.
package smart_home_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SHUTDOWN = 2'b01,
    ST_RECOVER  = 2'b10
  } state_t;

  localparam int unsigned LOAD_LIGHT = 0;
  localparam int unsigned LOAD_FAN   = 1;
  localparam int unsigned LOAD_AC    = 2;
  localparam int unsigned LOAD_HEAT  = 3;
  localparam int unsigned LOAD_COOL  = 4;

  function automatic int unsigned timer_max(input int unsigned on_cycles,
                                            input int unsigned off_cycles);
    return (on_cycles > off_cycles) ? on_cycles : off_cycles;
  endfunction

  function automatic int unsigned timer_width(input int unsigned on_cycles,
                                              input int unsigned off_cycles);
    int unsigned m;
    m = timer_max(on_cycles, off_cycles);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/load_power_scheduler_if.sv
// Request/grant bundle between mode logic (master) and the scheduler (slave).
interface load_power_scheduler_if #(
  parameter int unsigned NUM_LOADS = 5
);
  logic                               emergency_shutdown;
  logic [NUM_LOADS-1:0]               request;
  logic [NUM_LOADS-1:0]               grant;
  logic [NUM_LOADS-1:0]               pending;
  logic [1:0]                         fsm_state;
  logic [$clog2(NUM_LOADS+1)-1:0]     active_count;

  modport master (
    output emergency_shutdown, request,
    input  grant, pending, fsm_state, active_count
  );

  modport slave (
    input  emergency_shutdown, request,
    output grant, pending, fsm_state, active_count
  );
endinterface

// File: rtl/load_power_scheduler_load_hold_timer.sv
// Saturating per-load hold timer; cleared whenever the load's grant changes.
module load_hold_timer
  import smart_home_pkg::*;
#(
  parameter int unsigned MIN_ON_CYCLES  = 16,
  parameter int unsigned MIN_OFF_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_on_ok,
  output logic o_off_ok
);
  localparam int unsigned TW  = timer_width(MIN_ON_CYCLES, MIN_OFF_CYCLES);
  localparam logic [TW-1:0] SAT   = TW'(timer_max(MIN_ON_CYCLES, MIN_OFF_CYCLES));
  localparam logic [TW-1:0] ON_T  = TW'(MIN_ON_CYCLES);
  localparam logic [TW-1:0] OFF_T = TW'(MIN_OFF_CYCLES);

  logic [TW-1:0] r_count;

  // Reset to saturation so every load is eligible straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                r_count <= SAT;
    else if (i_clear)         r_count <= '0;
    else if (r_count != SAT)  r_count <= r_count + 1'b1;
  end

  assign o_on_ok  = (r_count >= ON_T);
  assign o_off_ok = (r_count >= OFF_T);
endmodule

// File: rtl/load_power_scheduler.sv
// Budgeted, mutex-aware load arbiter with emergency shutdown and recovery FSM.
module load_power_scheduler
  import smart_home_pkg::*;
#(
  parameter int unsigned NUM_LOADS      = 5,
  parameter int unsigned MAX_ACTIVE     = 2,
  parameter int unsigned MIN_ON_CYCLES  = 16,
  parameter int unsigned MIN_OFF_CYCLES = 16,
  parameter int unsigned RECOVER_CYCLES = 32,
  parameter int unsigned MUTEX_A        = LOAD_HEAT,
  parameter int unsigned MUTEX_B        = LOAD_COOL
) (
  input  logic                   clock,
  input  logic                   reset,
  load_power_scheduler_if.slave  bus
);
  localparam int unsigned CW  = $clog2(NUM_LOADS + 1);
  localparam int unsigned RCW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RECOVER_CYCLES - 1);

  state_t               r_state, w_state_next;
  logic [RCW-1:0]       r_rcnt, w_rcnt_next;
  logic [NUM_LOADS-1:0] r_grant, w_grant_next;
  logic [NUM_LOADS-1:0] r_pending, w_pending_next;
  logic [CW-1:0]        r_count, w_count_next;
  logic [NUM_LOADS-1:0] w_on_ok, w_off_ok, w_keep, w_sel, w_clear;

  for (genvar g = 0; g < NUM_LOADS; g++) begin : g_timer
    load_hold_timer #(
      .MIN_ON_CYCLES (MIN_ON_CYCLES),
      .MIN_OFF_CYCLES(MIN_OFF_CYCLES)
    ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .i_clear (w_clear[g]),
      .o_on_ok (w_on_ok[g]),
      .o_off_ok(w_off_ok[g])
    );
  end

  // Release, then fill the remaining budget in fixed priority order.
  always_comb begin
    int unsigned used;
    logic        elig;
    w_keep = r_grant & (bus.request | ~w_on_ok);
    w_sel  = '0;
    used   = 0;
    elig   = 1'b0;
    for (int unsigned i = 0; i < NUM_LOADS; i++)
      used = used + int'(w_keep[i]);
    for (int unsigned i = 0; i < NUM_LOADS; i++) begin
      elig = !r_grant[i] && bus.request[i] && w_off_ok[i];
      if (i == MUTEX_A && (w_keep[MUTEX_B] || w_sel[MUTEX_B])) elig = 1'b0;
      if (i == MUTEX_B && (w_keep[MUTEX_A] || w_sel[MUTEX_A])) elig = 1'b0;
      if (elig && used < MAX_ACTIVE) begin
        w_sel[i] = 1'b1;
        used     = used + 1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rcnt_next  = r_rcnt;
    w_grant_next = '0;
    if (bus.emergency_shutdown) begin
      w_state_next = ST_SHUTDOWN;
    end else begin
      unique case (r_state)
        ST_RUN:      w_grant_next = w_keep | w_sel;
        ST_SHUTDOWN: begin
          w_state_next = ST_RECOVER;
          w_rcnt_next  = '0;
        end
        ST_RECOVER: begin
          if (r_rcnt == RC_LAST) w_state_next = ST_RUN;
          else                   w_rcnt_next  = r_rcnt + 1'b1;
        end
        default:     w_state_next = ST_RUN;
      endcase
    end
    w_clear        = w_grant_next ^ r_grant;
    w_pending_next = bus.request & ~w_grant_next;
    w_count_next   = '0;
    for (int unsigned i = 0; i < NUM_LOADS; i++)
      w_count_next = w_count_next + CW'(w_grant_next[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_rcnt    <= '0;
      r_grant   <= '0;
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rcnt    <= w_rcnt_next;
      r_grant   <= w_grant_next;
      r_pending <= w_pending_next;
      r_count   <= w_count_next;
    end
  end

  assign bus.grant        = r_grant;
  assign bus.pending      = r_pending;
  assign bus.active_count = r_count;
  assign bus.fsm_state    = r_state;
endmodule

// File: tb/tb_load_power_scheduler.sv
// Scoreboard bench: directed steps push expected outputs, a monitor pops and compares.
module tb_load_power_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  load_power_scheduler_if #(.NUM_LOADS(5)) bus();

  load_power_scheduler #(
    .NUM_LOADS     (5),
    .MAX_ACTIVE    (2),
    .MIN_ON_CYCLES (4),
    .MIN_OFF_CYCLES(4),
    .RECOVER_CYCLES(8),
    .MUTEX_A       (3),
    .MUTEX_B       (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0] g;
    logic [1:0] s;
    logic [2:0] c;
    logic [4:0] p;
    int         id;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int step_id = 0;

  task automatic step(input logic [4:0] req, input logic em,
                      input logic [4:0] eg, input logic [1:0] es,
                      input logic [2:0] ec, input logic [4:0] ep);
    exp_t e;
    @(negedge clock);
    bus.request = req;
    bus.emergency_shutdown = em;
    @(posedge clock);
    e.g = eg; e.s = es; e.c = ec; e.p = ep; e.id = step_id;
    sb.push_back(e);
    step_id++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'b0, 1'b0, 5'b0, 2'b00, 3'd0, 5'b0);
  endtask

  task automatic check_now(input string name);
    total++;
    if (bus.grant !== 5'b0 || bus.fsm_state !== 2'b00 ||
        bus.active_count !== 3'd0 || bus.pending !== 5'b0) begin
      bad++;
      $display("FAIL %s: grant=%b state=%b count=%0d pending=%b, required all zero",
               name, bus.grant, bus.fsm_state, bus.active_count, bus.pending);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      total++;
      if ($countones(bus.grant) > 2) begin
        bad++;
        $display("FAIL budget_inv: grant=%b exceeds 2 active", bus.grant);
      end
      total++;
      if (bus.grant[3] && bus.grant[4]) begin
        bad++;
        $display("FAIL mutex_inv: grant=%b has both heat and cool", bus.grant);
      end
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (bus.grant !== e.g || bus.fsm_state !== e.s ||
          bus.active_count !== e.c || bus.pending !== e.p) begin
        bad++;
        $display("FAIL step%0d: got grant=%b state=%b count=%0d pending=%b, need grant=%b state=%b count=%0d pending=%b",
                 e.id, bus.grant, bus.fsm_state, bus.active_count, bus.pending,
                 e.g, e.s, e.c, e.p);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.request = '0;
    bus.emergency_shutdown = 1'b0;
    repeat (2) @(posedge clock);
    #1 check_now("reset_state");
    @(negedge clock);
    reset = 1'b0;

    // budget, then release-and-refill
    repeat (5) step(5'b00111, 1'b0, 5'b00011, 2'b00, 3'd2, 5'b00100);
    step(5'b00110, 1'b0, 5'b00110, 2'b00, 3'd2, 5'b00000);
    repeat (4) step(5'b00000, 1'b0, 5'b00100, 2'b00, 3'd1, 5'b00000);
    step(5'b00000, 1'b0, 5'b00000, 2'b00, 3'd0, 5'b00000);
    idle(4);

    // min-on hold, then min-off before re-grant
    step(5'b00001, 1'b0, 5'b00001, 2'b00, 3'd1, 5'b00000);
    repeat (4) step(5'b00000, 1'b0, 5'b00001, 2'b00, 3'd1, 5'b00000);
    step(5'b00000, 1'b0, 5'b00000, 2'b00, 3'd0, 5'b00000);
    repeat (4) step(5'b00001, 1'b0, 5'b00000, 2'b00, 3'd0, 5'b00001);
    step(5'b00001, 1'b0, 5'b00001, 2'b00, 3'd1, 5'b00000);
    repeat (4) step(5'b00000, 1'b0, 5'b00001, 2'b00, 3'd1, 5'b00000);
    step(5'b00000, 1'b0, 5'b00000, 2'b00, 3'd0, 5'b00000);
    idle(4);

    // heat/cool mutual exclusion with same-edge handover
    repeat (5) step(5'b11000, 1'b0, 5'b01000, 2'b00, 3'd1, 5'b10000);
    step(5'b10000, 1'b0, 5'b10000, 2'b00, 3'd1, 5'b00000);
    repeat (4) step(5'b00000, 1'b0, 5'b10000, 2'b00, 3'd1, 5'b00000);
    step(5'b00000, 1'b0, 5'b00000, 2'b00, 3'd0, 5'b00000);
    idle(4);

    // emergency shutdown and recovery
    step(5'b00011, 1'b0, 5'b00011, 2'b00, 3'd2, 5'b00000);
    repeat (3) step(5'b00011, 1'b1, 5'b00000, 2'b01, 3'd0, 5'b00011);
    repeat (8) step(5'b00011, 1'b0, 5'b00000, 2'b10, 3'd0, 5'b00011);
    step(5'b00011, 1'b0, 5'b00000, 2'b00, 3'd0, 5'b00011);
    step(5'b00011, 1'b0, 5'b00011, 2'b00, 3'd2, 5'b00000);

    // async reset in the middle of RECOVER
    step(5'b00000, 1'b1, 5'b00000, 2'b01, 3'd0, 5'b00000);
    repeat (2) step(5'b00000, 1'b0, 5'b00000, 2'b10, 3'd0, 5'b00000);
    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_now("reset_mid_recover");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step(5'b00000, 1'b0, 5'b00000, 2'b00, 3'd0, 5'b00000);
    step(5'b00001, 1'b0, 5'b00001, 2'b00, 3'd1, 5'b00000);
    step(5'b00011, 1'b0, 5'b00011, 2'b00, 3'd2, 5'b00000);

    // async reset with grants held under min-on
    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_now("reset_mid_run");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus.request = '0;
    step(5'b00000, 1'b0, 5'b00000, 2'b00, 3'd0, 5'b00000);

    @(negedge clock);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
